// File: rtl/axis_spi_pkg.sv
// Shared SPI definitions: slave FSM states and CPOL/CPHA derivation from the SPI mode number.
package axis_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } spi_state_e;

    function automatic logic spi_cpol(input int unsigned mode);
        return (mode >= 32'd2);
    endfunction

    function automatic logic spi_cpha(input int unsigned mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a selectable reset level.
module spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sync <= {STAGES{i_rst_val}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/axis_spi_slave.sv
// SPI slave bridging MOSI words to an AXI-Stream master and s_axis words onto MISO.
// Optional sticky overrun_o/underrun_o ports with AXIS_SPI_SLAVE_STATUS_EN defined.
module axis_spi_slave
    import axis_spi_pkg::*;
#(
    parameter int unsigned SPI_MODE    = 1,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic                  i_s_axis_tvalid,
    output logic                  o_s_axis_tready,
    input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
    output logic                  o_m_axis_tvalid,
    input  logic                  i_m_axis_tready,
    output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tlast
`ifdef AXIS_SPI_SLAVE_STATUS_EN
    ,
    output logic                  overrun_o,
    output logic                  underrun_o
`endif
);

    localparam logic        CPOL  = spi_cpol(SPI_MODE);
    localparam logic        CPHA  = spi_cpha(SPI_MODE);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    spi_state_e r_state, w_state_nxt;

    logic w_sck, w_cs, w_mosi;
    logic r_sck_d;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_rx_sh;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic [DATA_WIDTH-1:0] r_tx_hold;
    logic                  r_s_tready;
    logic                  r_miso, r_miso_oe;
    logic [DATA_WIDTH-1:0] r_pend;
    logic                  r_pend_valid;
    logic                  r_m_tvalid, r_m_tlast;
    logic [DATA_WIDTH-1:0] r_m_tdata;

    logic w_lead, w_trail, w_active, w_sample, w_shift, w_last_bit, w_word_done;
    logic w_cs_fall, w_load, w_s_hs, w_emit, w_out_blocked;
    logic [DATA_WIDTH-1:0] w_rx_word, w_load_word;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i(clk_i), .arstn_i(arstn_i), .i_rst_val(CPOL), .i_d(spi_clk_i), .o_q(w_sck)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(clk_i), .arstn_i(arstn_i), .i_rst_val(1'b1), .i_d(spi_cs_i), .o_q(w_cs)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk_i), .arstn_i(arstn_i), .i_rst_val(1'b0), .i_d(spi_mosi_i), .o_q(w_mosi)
    );

    // Edge strobes from the last two synchronized SCK samples
    assign w_lead      = (r_sck_d == CPOL) && (w_sck != CPOL);
    assign w_trail     = (r_sck_d != CPOL) && (w_sck == CPOL);
    assign w_active    = (r_state == ST_ACTIVE) && !w_cs;
    assign w_sample    = w_active && (CPHA ? w_trail : w_lead);
    // CPHA=0 skips the trailing edge right after a word boundary: the new MSB is already out
    assign w_shift     = w_active && (CPHA ? w_lead : (w_trail && (r_bit_cnt != '0)));
    assign w_last_bit  = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign w_word_done = w_sample && w_last_bit;
    assign w_rx_word   = {r_rx_sh, w_mosi};

    assign w_cs_fall   = (r_state == ST_IDLE) && !w_cs;
    assign w_load      = w_cs_fall || w_word_done;
    assign w_s_hs      = i_s_axis_tvalid && r_s_tready;
    assign w_load_word = !r_s_tready ? r_tx_hold : (w_s_hs ? i_s_axis_tdata : '0);

    assign w_emit        = r_pend_valid && (w_word_done || (r_state == ST_FLUSH));
    assign w_out_blocked = r_m_tvalid && !i_m_axis_tready;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (!w_cs) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs)  w_state_nxt = ST_FLUSH;
            ST_FLUSH:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // RX shifter and bit counter; a partial word is abandoned when CS rises
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sck_d   <= CPOL;
            r_miso_oe <= 1'b0;
            r_bit_cnt <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_sck_d   <= w_sck;
            r_miso_oe <= !w_cs;
            if (r_state != ST_ACTIVE) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_rx_sh   <= w_rx_word[DATA_WIDTH-2:0];
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // TX holding register and MISO shifter
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_tx_hold  <= '0;
            r_s_tready <= 1'b1;
            r_tx_sh    <= '0;
            r_miso     <= 1'b0;
        end else begin
            if (w_load) begin
                r_s_tready <= 1'b1;
            end else if (w_s_hs) begin
                r_tx_hold  <= i_s_axis_tdata;
                r_s_tready <= 1'b0;
            end

            if (w_load) begin
                if (CPHA) begin
                    r_tx_sh <= w_load_word;
                end else begin
                    r_miso  <= w_load_word[DATA_WIDTH-1];
                    r_tx_sh <= {w_load_word[DATA_WIDTH-2:0], 1'b0};
                end
            end else if (w_shift) begin
                r_miso  <= r_tx_sh[DATA_WIDTH-1];
                r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
            end else if (r_state == ST_FLUSH) begin
                r_miso  <= 1'b0;
                r_tx_sh <= '0;
            end
        end
    end

    // One-word pending buffer; its word leaves as a non-last word or, in FLUSH, as tlast
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tlast    <= 1'b0;
        end else begin
            if (r_m_tvalid && i_m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_emit && !w_out_blocked) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= r_pend;
                r_m_tlast  <= (r_state == ST_FLUSH);
            end
            if (w_word_done) begin
                r_pend       <= w_rx_word;
                r_pend_valid <= 1'b1;
            end else if (r_state == ST_FLUSH) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

`ifdef AXIS_SPI_SLAVE_STATUS_EN
    logic w_overrun, w_underrun;
    logic r_overrun, r_underrun;

    assign w_overrun  = w_emit && w_out_blocked;
    assign w_underrun = w_load && r_s_tready && !i_s_axis_tvalid;

    // Sticky flags, restarted at each CS fall
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else if (w_cs_fall) begin
            r_overrun  <= w_overrun;
            r_underrun <= w_underrun;
        end else begin
            r_overrun  <= r_overrun  | w_overrun;
            r_underrun <= r_underrun | w_underrun;
        end
    end

    assign overrun_o  = r_overrun;
    assign underrun_o = r_underrun;
`endif

    assign spi_miso_o      = r_miso;
    assign spi_miso_oe_o   = r_miso_oe;
    assign o_s_axis_tready = r_s_tready;
    assign o_m_axis_tvalid = r_m_tvalid;
    assign o_m_axis_tdata  = r_m_tdata;
    assign o_m_axis_tlast  = r_m_tlast;

endmodule

// File: doc/axis_spi_slave.md
AXIS_SPI_SLAVE -- requirements
Module: axis_spi_slave

Interface
REQ-001 Parameter SPI_MODE, default 1, meaning SPI mode 0..3; CPOL = mode 2/3, CPHA = mode 1/3.
REQ-002 Parameter DATA_WIDTH, default 8, meaning bits per SPI word and AXIS tdata width.
REQ-003 Parameter SYNC_STAGES, default 2, meaning flip-flop count of each input synchronizer (minimum 2).
REQ-004 clk_i  input  1  system clock; SPI clock frequency SHALL be at most clk_i/8.
REQ-005 arstn_i  input  1  asynchronous active-low reset.
REQ-006 spi_clk_i  input  1  SPI clock from the master, asynchronous to clk_i.
REQ-007 spi_cs_i  input  1  chip select, active low.
REQ-008 spi_mosi_i  input  1  serial data from the master.
REQ-009 spi_miso_o  output  1  serial data to the master.
REQ-010 spi_miso_oe_o  output  1  MISO output enable, high while synchronized CS is low.
REQ-011 s_axis  axis_if.slave  DATA_WIDTH  words to transmit on MISO; tlast ignored.
REQ-012 m_axis  axis_if.master  DATA_WIDTH  words received on MOSI; tlast marks the last word of a CS frame.

Function
REQ-013 spi_clk_i, spi_cs_i and spi_mosi_i SHALL each pass through a SYNC_STAGES synchronizer; SCK edges SHALL be detected from the last two synchronized samples.
- Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
REQ-014 FSM states SHALL be IDLE (CS high), ACTIVE (CS low, shifting) and FLUSH (one cycle after CS rises); IDLE->ACTIVE on synchronized CS fall, ACTIVE->FLUSH on CS rise, FLUSH->IDLE unconditionally.
REQ-015 RX sampling: MOSI SHALL be sampled on the leading edge when CPHA=0 and on the trailing edge when CPHA=1, MSB first, into a DATA_WIDTH shift register with a bit counter.
REQ-016 TX shifting, CPHA=0: MSB SHALL be on spi_miso_o in the cycle after the word loads; subsequent bits change on trailing edges.
REQ-017 TX shifting, CPHA=1: each bit, MSB first, SHALL be driven on leading edges.
REQ-018 TX holding register: s_axis.tready = ~tx_full; a handshake sets tx_full and captures tdata.
REQ-019 TX word load: a word SHALL be loaded at CS fall and at every DATA_WIDTH-bit boundary.
- Load takes the holding register and clears tx_full when full.
- Otherwise it loads all-zeros and flags underrun.
REQ-020 A handshake coinciding with a load SHALL be captured and consumed in the same cycle; tx_full ends 0.
REQ-021 RX pending register: each completed word goes to a one-word pending register.
- The previous pending word SHALL be emitted with tlast=0 when a new word completes.
- The pending word SHALL be emitted with tlast=1 in FLUSH.
- Partial words at CS rise SHALL be discarded.
REQ-022 m_axis.tvalid SHALL hold until m_axis.tready; tdata and tlast SHALL be stable while valid and not ready.
REQ-023 Overrun: if a word must be emitted while m_axis.tvalid=1 and m_axis.tready=0, the new word SHALL be dropped and overrun flagged; the output word is untouched.
REQ-024 Latency from an SCK sampling edge at the pins to the bit in the shift register SHALL be SYNC_STAGES+1 clk_i cycles.
REQ-025 CS rise mid-word SHALL reset the bit counter and TX shifter; the TX holding register SHALL be kept.

Reset
REQ-026 On arstn_i low, all outputs and state SHALL clear asynchronously:
- state IDLE; m_axis.tvalid, tlast, tdata 0; s_axis.tready 1;
- spi_miso_o 0; spi_miso_oe_o 0;
- synchronizers reset to CS=1 and SCK=CPOL.

Configuration
REQ-027 With AXIS_SPI_SLAVE_STATUS_EN defined, output ports overrun_o and underrun_o (1 bit each) SHALL exist.
- Each is a sticky flag set per REQ-023 / REQ-019.
- Both clear on the next CS fall and on reset.
REQ-028 Without AXIS_SPI_SLAVE_STATUS_EN, those ports and their logic SHALL be absent; data-path behaviour is identical.

Structure
REQ-029 Package axis_spi_pkg SHALL hold the state enum (IDLE/ACTIVE/FLUSH) and the CPOL/CPHA derivation functions shared with the master.
REQ-030 Sub-module spi_sync (parameterised SYNC_STAGES, reset value port) SHALL implement each synchronizer.

Verification
REQ-031 Mode 0: preload 0xA5 on s_axis; master sends 0x3C in one frame -> MISO bits 1010_0101; m_axis 0x3C with tlast=1.
REQ-032 Mode 1 and mode 3: 3-word frame 0x01,0x02,0x03 with tready=1 -> m_axis 0x01(tlast 0), 0x02(tlast 0), 0x03(tlast 1).
REQ-033 Mode 2: no s_axis data; 2-word frame -> MISO all zeros; underrun_o=1 (STATUS_EN build).
REQ-034 m_axis.tready=0 during a 3-word frame 0x11,0x22,0x33 -> only 0x11 output; overrun_o=1; 0x22 and 0x33 lost.
REQ-035 CS rises after 5 bits of a mode 0 word, then a full word 0x7E -> no partial output; next output 0x7E tlast=1.
REQ-036 arstn_i asserted mid-frame -> all outputs at reset values within 0 clk_i cycles; clean transfer after release.
